gpio_mmio: RTL

//  Parametrised memory-mapped GPIO peripheral on the core's io_* bus. Successor to the fixed LED/SW/PB register block.

---
 rtl/gpio_pkg.sv | 18 +
 rtl/gpio_debounce.sv | 50 +++++
 rtl/gpio_mmio.sv | 114 +++++++++++
 3 files changed

// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO MMIO block: register word offsets and the
// byte-enable expansion helper.
package gpio_pkg;

  typedef logic [2:0] gpio_off_t;

  localparam gpio_off_t GPIO_LED     = 3'd0;
  localparam gpio_off_t GPIO_SW      = 3'd1;
  localparam gpio_off_t GPIO_PB      = 3'd2;
  localparam gpio_off_t GPIO_PB_EDGE = 3'd3;
  localparam gpio_off_t GPIO_IRQ_EN  = 3'd4;
  localparam gpio_off_t GPIO_LED_TGL = 3'd5;

  function automatic logic [31:0] be_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/gpio_debounce.sv
// One-bit input conditioner: 2-FF synchroniser followed by a debounce counter
// that flips the output after DB_CYCLES consecutive disagreeing samples.
module gpio_debounce #(
  parameter int unsigned DB_CYCLES = 50000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pin_i,
  output logic out_level,
  output logic rise_o
);

  localparam int unsigned    CntW   = $clog2(DB_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DB_CYCLES - 1);

  logic            sync1_q, sync2_q;
  logic            level_q, level_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CntMax) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= pin_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_level = level_q;
  // Pulses on the edge where the debounced level will go 0->1.
  assign rise_o    = level_d & ~level_q;

endmodule

// File: rtl/gpio_mmio.sv
// Memory-mapped GPIO: LED register with toggle port, debounced switches and
// buttons, sticky W1C button-edge flags and a masked level interrupt.
module gpio_mmio
  import gpio_pkg::*;
#(
  parameter int unsigned N_LED     = 8,
  parameter int unsigned N_SW      = 16,
  parameter int unsigned N_PB      = 5,
  parameter int unsigned DB_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      io_addr,
  input  logic             io_we,
  input  logic             io_re,
  input  logic [3:0]       io_be,
  input  logic [31:0]      io_wdata,
  output logic [31:0]      io_rdata,
  input  logic [N_SW-1:0]  sw_in,
  input  logic [N_PB-1:0]  pb_in,
  output logic [N_LED-1:0] leds_out,
  output logic             irq
);

  gpio_off_t        off;
  logic [31:0]      bmask, wmask;
  logic [N_SW-1:0]  sw_db, unused_sw_rise;
  logic [N_PB-1:0]  pb_db, pb_rise;
  logic [N_LED-1:0] led_q, led_d;
  logic [N_PB-1:0]  edge_q, edge_d;
  logic [N_PB-1:0]  irq_en_q, irq_en_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             unused_addr;

  assign off         = io_addr[4:2];
  assign unused_addr = ^{io_addr[31:5], io_addr[1:0]};
  assign bmask       = be_mask(io_be);
  assign wmask       = io_wdata & bmask;

  for (genvar i = 0; i < N_SW; i++) begin : g_sw
    gpio_debounce #(
      .DB_CYCLES(DB_CYCLES)
    ) u_db (
      .clk_i    (clk),
      .rst_i    (reset),
      .pin_i    (sw_in[i]),
      .out_level(sw_db[i]),
      .rise_o   (unused_sw_rise[i])
    );
  end

  for (genvar i = 0; i < N_PB; i++) begin : g_pb
    gpio_debounce #(
      .DB_CYCLES(DB_CYCLES)
    ) u_db (
      .clk_i    (clk),
      .rst_i    (reset),
      .pin_i    (pb_in[i]),
      .out_level(pb_db[i]),
      .rise_o   (pb_rise[i])
    );
  end

  always_comb begin
    led_d    = led_q;
    edge_d   = edge_q;
    irq_en_d = irq_en_q;
    rdata_d  = rdata_q;

    // Read mux sees pre-update register contents.
    if (io_re) begin
      case (off)
        GPIO_LED:     rdata_d = 32'(led_q);
        GPIO_SW:      rdata_d = 32'(sw_db);
        GPIO_PB:      rdata_d = 32'(pb_db);
        GPIO_PB_EDGE: rdata_d = 32'(edge_q);
        GPIO_IRQ_EN:  rdata_d = 32'(irq_en_q);
        default:      rdata_d = '0;
      endcase
    end

    if (io_we) begin
      case (off)
        GPIO_LED:     led_d    = N_LED'((32'(led_q) & ~bmask) | wmask);
        GPIO_PB_EDGE: edge_d   = N_PB'(32'(edge_q) & ~wmask);
        GPIO_IRQ_EN:  irq_en_d = N_PB'((32'(irq_en_q) & ~bmask) | wmask);
        GPIO_LED_TGL: led_d    = N_LED'(32'(led_q) ^ wmask);
        default:      ;
      endcase
    end

    // Applied after the W1C so a same-cycle new edge keeps the flag set.
    edge_d = edge_d | pb_rise;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      led_q    <= '0;
      edge_q   <= '0;
      irq_en_q <= '0;
      rdata_q  <= '0;
    end else begin
      led_q    <= led_d;
      edge_q   <= edge_d;
      irq_en_q <= irq_en_d;
      rdata_q  <= rdata_d;
    end
  end

  assign leds_out = led_q;
  assign io_rdata = rdata_q;
  assign irq      = |(edge_q & irq_en_q);

endmodule
